// File: rtl/tms9918_cpu_port_pkg.sv
// Shared types and timing defaults for the TMS9918 CPU-side port initiator.
package tms9918_cpu_port_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_RECOVER
    } state_e;

    localparam int unsigned DEF_SETUP_CYCLES    = 2;
    localparam int unsigned DEF_STROBE_CYCLES   = 6;
    localparam int unsigned DEF_HOLD_CYCLES     = 2;
    localparam int unsigned DEF_RECOVERY_CYCLES = 4;

    localparam logic PORT_DATA = 1'b0;
    localparam logic PORT_REG  = 1'b1;

    typedef struct packed {
        logic       write;
        logic       mode;
        logic [7:0] data;
    } req_t;

    // Counter load value for an N-cycle phase; the phase ends when the counter reads 0.
    function automatic logic [7:0] ld_val(input int unsigned n);
        return (n == 0) ? 8'd0 : 8'(n - 1);
    endfunction

endpackage

// File: rtl/tms9918_cpu_port_sync2.sv
// Two-flop synchronizer with a selectable reset value.
module tms9918_cpu_port_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [1:0] ff_q;
    logic [1:0] ff_d;

    always_comb ff_d = {ff_q[0], d};

    always_ff @(posedge clk) begin
        if (!reset_n) ff_q <= {2{RST_VAL}};
        else          ff_q <= ff_d;
    end

    assign q = ff_q[1];

endmodule

// File: rtl/tms9918_cpu_port.sv
// CPU-side initiator: turns a one-word request into a timed csr_n/csw_n cycle
// toward the VDP, captures read data and synchronizes the VDP interrupt back.
module tms9918_cpu_port
    import tms9918_cpu_port_pkg::*;
#(
    parameter int unsigned SETUP_CYCLES    = DEF_SETUP_CYCLES,
    parameter int unsigned STROBE_CYCLES   = DEF_STROBE_CYCLES,
    parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int unsigned RECOVERY_CYCLES = DEF_RECOVERY_CYCLES
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic       req_mode,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       csr_n,
    output logic       csw_n,
    output logic       mode,
    output logic [7:0] cd_o,
    input  logic [7:0] cd_i,
    input  logic       vdp_int_n,
    output logic       int_n
);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    req_t       req_q, req_d;
    logic [7:0] rdata_q, rdata_d;
    logic       ready_q, ready_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic       csr_n_q, csr_n_d;
    logic       csw_n_q, csw_n_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && ready_q) begin
                    req_d.write = req_write;
                    req_d.mode  = req_mode;
                    req_d.data  = req_write ? req_wdata : 8'd0;
                    state_d     = ST_SETUP;
                    cnt_d       = ld_val(SETUP_CYCLES);
                end
            end
            ST_SETUP: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_STROBE;
                    cnt_d   = ld_val(STROBE_CYCLES);
                end else cnt_d = cnt_q - 8'd1;
            end
            ST_STROBE: begin
                if (cnt_q == 8'd0) begin
                    if (!req_q.write) rdata_d = cd_i;
                    state_d = ST_HOLD;
                    cnt_d   = ld_val(HOLD_CYCLES);
                end else cnt_d = cnt_q - 8'd1;
            end
            ST_HOLD: begin
                if (cnt_q == 8'd0) begin
                    state_d = (RECOVERY_CYCLES == 0) ? ST_IDLE : ST_RECOVER;
                    cnt_d   = ld_val(RECOVERY_CYCLES);
                end else cnt_d = cnt_q - 8'd1;
            end
            ST_RECOVER: begin
                if (cnt_q == 8'd0) state_d = ST_IDLE;
                else               cnt_d   = cnt_q - 8'd1;
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so every port pin comes straight off a flop.
        ready_d     = (state_d == ST_IDLE);
        csw_n_d     = !((state_d == ST_STROBE) &&  req_d.write);
        csr_n_d     = !((state_d == ST_STROBE) && !req_d.write);
        rsp_valid_d = (state_d == ST_HOLD) && (cnt_d == 8'd0);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 8'd0;
            req_q       <= '0;
            rdata_q     <= 8'd0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            csr_n_q     <= 1'b1;
            csw_n_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            rdata_q     <= rdata_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            csr_n_q     <= csr_n_d;
            csw_n_q     <= csw_n_d;
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign csr_n     = csr_n_q;
    assign csw_n     = csw_n_q;
    assign mode      = req_q.mode;
    assign cd_o      = req_q.data;

    tms9918_cpu_port_sync2 #(.RST_VAL(1'b1)) u_int_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (vdp_int_n),
        .q       (int_n)
    );

endmodule

// File: tb/tb_tms9918_cpu_port.sv
// Directed bench for tms9918_cpu_port: table of single transactions plus
// hand-written reset, back-to-back, abort and interrupt sequences.
module tb_tms9918_cpu_port;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_write = 1'b0;
    logic       req_mode = 1'b0;
    logic [7:0] req_wdata = 8'd0;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       csr_n, csw_n, mode;
    logic [7:0] cd_o;
    logic [7:0] cd_i = 8'd0;
    logic       vdp_int_n = 1'b1;
    logic       int_n;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tms9918_cpu_port dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_mode  (req_mode),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .csr_n     (csr_n),
        .csw_n     (csw_n),
        .mode      (mode),
        .cd_o      (cd_o),
        .cd_i      (cd_i),
        .vdp_int_n (vdp_int_n),
        .int_n     (int_n)
    );

    typedef struct {
        logic       wr;
        logic       md;
        logic [7:0] wd;
        logic [7:0] cdi;
        logic [7:0] exp_cd;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // One transaction; sample index k is the k-th cycle after the accept cycle.
    task automatic do_txn(input vec_t v, input string nm);
        int          n = 0;
        logic [16:0] lo_m, other_m, rsp_m, rdy_m;
        int          mode_bad = 0, cd_bad = 0;
        logic [7:0]  rd_at_rsp = 8'hxx;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_wait_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_write = v.wr;
        req_mode  = v.md;
        req_wdata = v.wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_write = ~v.wr;
        req_mode  = ~v.md;
        req_wdata = ~v.wd;
        lo_m = '0; other_m = '0; rsp_m = '0; rdy_m = '0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            lo_m[k]    = v.wr ? !csw_n : !csr_n;
            other_m[k] = v.wr ? !csr_n : !csw_n;
            rsp_m[k]   = rsp_valid;
            if (k <= 15) rdy_m[k] = req_ready;
            if (k <= 10 && mode !== v.md) mode_bad++;
            if (k <= 10 && cd_o !== v.exp_cd) cd_bad++;
            if (rsp_valid) rd_at_rsp = rsp_rdata;
            cd_i = (k >= 3 && k <= 8) ? v.cdi : ~v.cdi;
        end
        chk({nm, "_strobe_mask"}, 32'(lo_m), 32'h0001F8);
        chk({nm, "_other_strobe"}, 32'(other_m), 32'h0);
        chk({nm, "_rsp_mask"}, 32'(rsp_m), 32'h000400);
        chk({nm, "_ready_mask"}, 32'(rdy_m), 32'h008000);
        chk({nm, "_mode_stable"}, 32'(mode_bad), 32'd0);
        chk({nm, "_cd_o_stable"}, 32'(cd_bad), 32'd0);
        chk({nm, "_rdata"}, 32'(rd_at_rsp), 32'(v.exp_rd));
    endtask

    initial begin
        int         acc;
        int         acc_idx[2];
        int         both_lo, lo11, lo22, rsp_cnt, rsp_after;
        logic [9:0] int_seen;

        vecs[0] = '{wr: 1'b1, md: 1'b1, wd: 8'h87, cdi: 8'h00, exp_cd: 8'h87, exp_rd: 8'h00};
        vecs[1] = '{wr: 1'b0, md: 1'b0, wd: 8'hFF, cdi: 8'h5A, exp_cd: 8'h00, exp_rd: 8'h5A};
        vecs[2] = '{wr: 1'b1, md: 1'b0, wd: 8'h3C, cdi: 8'h99, exp_cd: 8'h3C, exp_rd: 8'h5A};
        vecs[3] = '{wr: 1'b0, md: 1'b1, wd: 8'h42, cdi: 8'hA5, exp_cd: 8'h00, exp_rd: 8'hA5};
        vecs[4] = '{wr: 1'b1, md: 1'b1, wd: 8'h00, cdi: 8'h12, exp_cd: 8'h00, exp_rd: 8'hA5};
        vecs[5] = '{wr: 1'b0, md: 1'b0, wd: 8'h55, cdi: 8'hFF, exp_cd: 8'h00, exp_rd: 8'hFF};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_csr_n", 32'(csr_n), 32'd1);
        chk("rst_csw_n", 32'(csw_n), 32'd1);
        chk("rst_int_n", 32'(int_n), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_mode_cd", 32'({mode, cd_o, rsp_rdata}), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_ready_after", 32'(req_ready), 32'd1);

        for (int i = 0; i < 6; i++) do_txn(vecs[i], $sformatf("vec%0d", i));

        // Back-to-back writes with req_valid held high
        acc = 0; both_lo = 0; lo11 = 0; lo22 = 0; rsp_cnt = 0;
        acc_idx[0] = -1; acc_idx[1] = -1;
        req_valid = 1'b1; req_write = 1'b1; req_mode = 1'b0; req_wdata = 8'h11;
        for (int i = 0; i < 40; i++) begin
            if (i > 0) @(negedge clk);
            if (acc >= 1) req_wdata = 8'h22;
            if (acc >= 2) req_valid = 1'b0;
            if (!csr_n && !csw_n) both_lo++;
            if (!csw_n && cd_o == 8'h11) lo11++;
            if (!csw_n && cd_o == 8'h22) lo22++;
            if (rsp_valid) rsp_cnt++;
            if (req_ready && req_valid && acc < 2) begin
                acc_idx[acc] = i;
                acc++;
            end
        end
        req_valid = 1'b0;
        chk("b2b_accepts", 32'(acc), 32'd2);
        chk("b2b_spacing", 32'(acc_idx[1] - acc_idx[0]), 32'd15);
        chk("b2b_both_low", 32'(both_lo), 32'd0);
        chk("b2b_strobe_11", 32'(lo11), 32'd6);
        chk("b2b_strobe_22", 32'(lo22), 32'd6);
        chk("b2b_rsp_count", 32'(rsp_cnt), 32'd2);

        // Reset during the third strobe cycle of a write
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_mode = 1'b1; req_wdata = 8'hC3;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 1; k <= 5; k++) @(negedge clk);
        chk("abort_strobe_low", 32'(csw_n), 32'd0);
        reset_n = 1'b0;
        @(negedge clk);
        chk("abort_csw_high", 32'(csw_n), 32'd1);
        chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
        chk("abort_mode_cd", 32'({mode, cd_o}), 32'd0);
        reset_n = 1'b1;
        rsp_after = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (rsp_valid || !csw_n || !csr_n) rsp_after++;
        end
        chk("abort_quiet", 32'(rsp_after), 32'd0);
        do_txn(vecs[0], "post_abort");

        // Interrupt synchronizer: 5-cycle low pulse, 2-cycle latency
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            int_seen[i] = int_n;
            vdp_int_n = (i < 5) ? 1'b0 : 1'b1;
        end
        chk("int_pulse", 32'(int_seen), 32'h383);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
